// File: rtl/m_led_uart_reporter.sv
// Reports every change of the processor result bus as "XXXXXXXX\r\n" over an 8N1 UART line.
// Holds one pending value while a frame is in flight, so only the newest unsent value survives.
module m_led_uart_reporter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_ce,
  input  logic [31:0] w_data,
  output logic        w_txd,
  output logic        w_busy,
  output logic        w_ovf
);

  localparam int TW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} t_state;

  t_state        r_state, w_stateNext;
  logic [31:0]   r_last, w_lastNext;
  logic [31:0]   r_snap, w_snapNext;
  logic [31:0]   r_pend, w_pendNext;
  logic          r_pendValid, w_pendValidNext;
  logic [3:0]    r_charIdx, w_charIdxNext;
  logic [2:0]    r_bitIdx, w_bitIdxNext;
  logic [TW-1:0] r_timer, w_timerNext;
  logic          r_txd, w_txdNext;
  logic          r_busy, w_busyNext;
  logic          r_ovf, w_ovfNext;

  logic          w_capture;
  logic          w_bitEnd;
  logic          w_frameEnd;
  logic [31:0]   w_shifted;
  logic [3:0]    w_nib;
  logic [7:0]    w_char;
  logic [2:0]    w_bitIdxInc;

  assign w_capture   = w_ce && (w_data != r_last);
  assign w_bitEnd    = (r_timer == TW'(CLKS_PER_BIT - 1));
  assign w_frameEnd  = (r_state == S_STOP) && w_bitEnd && (r_charIdx == 4'd9);
  assign w_bitIdxInc = r_bitIdx + 3'd1;

  // Chars 0..7 walk the snapshot nibbles MSB first; chars 8 and 9 are CR LF.
  assign w_shifted = r_snap << {r_charIdx[2:0], 2'b00};
  assign w_nib     = w_shifted[31:28];

  always_comb begin
    w_char = 8'h0A;
    if (r_charIdx == 4'd8)
      w_char = 8'h0D;
    else if (r_charIdx < 4'd8)
      w_char = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib}) : (8'h37 + {4'h0, w_nib});
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_state     <= S_IDLE;
      r_last      <= '0;
      r_snap      <= '0;
      r_pend      <= '0;
      r_pendValid <= 1'b0;
      r_charIdx   <= '0;
      r_bitIdx    <= '0;
      r_timer     <= '0;
      r_txd       <= 1'b1;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_last      <= w_lastNext;
      r_snap      <= w_snapNext;
      r_pend      <= w_pendNext;
      r_pendValid <= w_pendValidNext;
      r_charIdx   <= w_charIdxNext;
      r_bitIdx    <= w_bitIdxNext;
      r_timer     <= w_timerNext;
      r_txd       <= w_txdNext;
      r_busy      <= w_busyNext;
      r_ovf       <= w_ovfNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_lastNext      = w_capture ? w_data : r_last;
    w_snapNext      = r_snap;
    w_pendNext      = r_pend;
    w_pendValidNext = r_pendValid;
    w_charIdxNext   = r_charIdx;
    w_bitIdxNext    = r_bitIdx;
    w_timerNext     = r_timer;
    w_txdNext       = r_txd;
    w_busyNext      = r_busy;
    w_ovfNext       = r_ovf;

    if (r_state != S_IDLE)
      w_timerNext = w_bitEnd ? '0 : r_timer + 1'b1;

    case (r_state)
      S_IDLE: begin
        if (w_capture) begin
          w_snapNext    = w_data;
          w_stateNext   = S_START;
          w_txdNext     = 1'b0;
          w_busyNext    = 1'b1;
          w_charIdxNext = '0;
          w_timerNext   = '0;
        end
      end
      S_START: begin
        if (w_bitEnd) begin
          w_stateNext  = S_DATA;
          w_bitIdxNext = '0;
          w_txdNext    = w_char[0];
        end
      end
      S_DATA: begin
        if (w_bitEnd) begin
          if (r_bitIdx == 3'd7) begin
            w_stateNext = S_STOP;
            w_txdNext   = 1'b1;
          end else begin
            w_bitIdxNext = w_bitIdxInc;
            w_txdNext    = w_char[w_bitIdxInc];
          end
        end
      end
      S_STOP: begin
        if (w_bitEnd) begin
          if (r_charIdx != 4'd9) begin
            w_charIdxNext = r_charIdx + 4'd1;
            w_stateNext   = S_START;
            w_txdNext     = 1'b0;
          end else if (r_pendValid || w_capture) begin
            w_snapNext      = r_pendValid ? r_pend : w_data;
            w_pendValidNext = 1'b0;
            w_charIdxNext   = '0;
            w_stateNext     = S_START;
            w_txdNext       = 1'b0;
          end else begin
            w_stateNext = S_IDLE;
            w_busyNext  = 1'b0;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase

    // At frame end the old pending value has just been consumed, so replacing it is not an overwrite.
    if (w_capture && (r_state != S_IDLE)) begin
      if (!w_frameEnd) begin
        w_pendNext      = w_data;
        w_pendValidNext = 1'b1;
        if (r_pendValid)
          w_ovfNext = 1'b1;
      end else if (r_pendValid) begin
        w_pendNext      = w_data;
        w_pendValidNext = 1'b1;
      end
    end
  end

  assign w_txd  = r_txd;
  assign w_busy = r_busy;
  assign w_ovf  = r_ovf;

endmodule
